// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module : ifetch_pkg
// Shared types and constants for the instruction fetch unit. Defining
// IFETCH_PREFETCH_EN selects the two-entry prefetch buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ifetch_pkg;

  localparam int INSTR_W = 16;

`ifdef IFETCH_PREFETCH_EN
  localparam int IFETCH_DEPTH = 2;
`else
  localparam int IFETCH_DEPTH = 1;
`endif

  localparam int IFETCH_CNT_W = $clog2(IFETCH_DEPTH + 1);

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FLUSH      = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_if.sv
// ============================================================================
// Module : ifetch_if
// Memory read channel, decoder-side instruction stream and branch redirect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ifetch_if #(
  parameter int ADDR_W = 16
);

  logic                             MEM_REQ;
  logic [ADDR_W-1:0]                MEM_ADDR;
  logic                             MEM_ACK;
  logic [ifetch_pkg::INSTR_W-1:0]   MEM_RDATA;
  logic [ifetch_pkg::INSTR_W-1:0]   INSTR;
  logic [ADDR_W-1:0]                INSTR_PC;
  logic                             INSTR_VALID;
  logic                             INSTR_READY;
  logic                             BRANCH;
  logic [ADDR_W-1:0]                BRANCH_TARGET;

  modport master (
    output MEM_REQ, MEM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    input  MEM_ACK, MEM_RDATA, INSTR_READY, BRANCH, BRANCH_TARGET
  );

  modport slave (
    input  MEM_REQ, MEM_ADDR, INSTR, INSTR_PC, INSTR_VALID,
    output MEM_ACK, MEM_RDATA, INSTR_READY, BRANCH, BRANCH_TARGET
  );

endinterface

`default_nettype wire

// File: rtl/ifetch_buf.sv
// ============================================================================
// Module : ifetch_buf
// Small synchronous FIFO of {word, pc} entries with push, pop and clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifetch_buf #(
  parameter int DEPTH  = 1,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                         CLK,
  input  logic                         nRESET,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  logic [WORD_W-1:0]            i_word,
  input  logic [ADDR_W-1:0]            i_pc,
  output logic [WORD_W-1:0]            o_word,
  output logic [ADDR_W-1:0]            o_pc,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] r_word [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    f_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_word[r_wr] <= i_word;
        r_pc[r_wr]   <= i_pc;
        r_wr         <= f_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= f_inc(r_rd);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_word  = r_word[r_rd];
  assign o_pc    = r_pc[r_rd];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Program counter, single-outstanding memory reads and buffered instruction
// delivery with branch flush. IFETCH_PREFETCH_EN enables a 2-deep buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic     CLK,
  input  logic     nRESET,
  ifetch_if.master bus
);

  fetch_state_t              r_state;
  fetch_state_t              w_state_nxt;
  logic [ADDR_W-1:0]         r_pc;
  logic [ADDR_W-1:0]         w_pc_nxt;
  logic [ADDR_W-1:0]         r_addr;
  logic [ADDR_W-1:0]         w_addr_nxt;
  logic                      r_req;
  logic                      w_ack;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_room;
  logic                      w_full;
  logic                      w_empty;
  logic [IFETCH_CNT_W-1:0]   w_occ;
  logic [INSTR_W-1:0]        w_head_word;
  logic [ADDR_W-1:0]         w_head_pc;

  // An ACK only counts against a request we actually raised.
  assign w_ack  = r_req && bus.MEM_ACK;
  assign w_push = w_ack && (r_state == FETCH_WAIT) && !bus.BRANCH;
  assign w_pop  = !w_empty && bus.INSTR_READY;

  // Room after this edge: a branch empties the buffer, otherwise push/pop net change.
  assign w_room = bus.BRANCH ? 1'b1 :
                  w_full     ? (w_pop && !w_push) :
                               !(w_push && !w_pop && (w_occ == IFETCH_CNT_W'(IFETCH_DEPTH - 1)));

  ifetch_buf #(
    .DEPTH  (IFETCH_DEPTH),
    .WORD_W (INSTR_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (bus.BRANCH),
    .i_word  (bus.MEM_RDATA),
    .i_pc    (r_addr),
    .o_word  (w_head_word),
    .o_pc    (w_head_pc),
    .o_count (w_occ),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      FETCH_IDLE: begin
        if (bus.BRANCH) w_pc_nxt = bus.BRANCH_TARGET;
        if (w_room)     w_state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (w_ack) begin
          w_pc_nxt    = bus.BRANCH ? bus.BRANCH_TARGET : r_pc + ADDR_W'(1);
          w_state_nxt = w_room ? FETCH_WAIT : FETCH_IDLE;
        end else if (bus.BRANCH) begin
          w_pc_nxt    = bus.BRANCH_TARGET;
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.BRANCH) w_pc_nxt = bus.BRANCH_TARGET;
        if (w_ack)      w_state_nxt = FETCH_WAIT;
      end
      default: w_state_nxt = FETCH_IDLE;
    endcase
    // A flushed request must keep its stale address until memory answers it.
    w_addr_nxt = (w_state_nxt == FLUSH) ? r_addr : w_pc_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= (w_state_nxt != FETCH_IDLE);
    end
  end

  assign bus.MEM_REQ     = r_req;
  assign bus.MEM_ADDR    = r_addr;
  assign bus.INSTR       = w_head_word;
  assign bus.INSTR_PC    = w_head_pc;
  assign bus.INSTR_VALID = !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Directed self-checking bench for instr_fetch_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        auto_mem = 1'b0;
  logic        man_ack = 1'b0;
  logic [15:0] man_rdata = 16'h0000;
  logic        a_ack = 1'b0;
  logic [15:0] a_rdata = 16'h0000;
  logic        ready = 1'b0;
  logic        branch = 1'b0;
  logic [15:0] target = 16'h0000;
  int          lat = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] cap_pc[$];
  logic [15:0] cap_w[$];
  int          cap_cyc[$];

  always #5 CLK = ~CLK;

  ifetch_if #(.ADDR_W(16)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  assign bus.MEM_ACK       = auto_mem ? a_ack : man_ack;
  assign bus.MEM_RDATA     = auto_mem ? a_rdata : man_rdata;
  assign bus.INSTR_READY   = ready;
  assign bus.BRANCH        = branch;
  assign bus.BRANCH_TARGET = target;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a * 16'h0011 + 16'h0813;
  endfunction

  // Memory model: acknowledges `lat` cycles after a request is first seen.
  always @(posedge CLK) begin
    #2;
    if (auto_mem && bus.MEM_REQ) begin
      if (wcnt >= lat) begin
        a_ack   = 1'b1;
        a_rdata = word_of(bus.MEM_ADDR);
        wcnt    = 0;
      end else begin
        a_ack = 1'b0;
        wcnt  = wcnt + 1;
      end
    end else begin
      a_ack = 1'b0;
      wcnt  = 0;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Consumer-side capture of every accepted instruction.
  always @(negedge CLK) begin
    if (nRESET && bus.INSTR_VALID && ready) begin
      cap_pc.push_back(bus.INSTR_PC);
      cap_w.push_back(bus.INSTR);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_caps();
    cap_pc.delete();
    cap_w.delete();
    cap_cyc.delete();
  endtask

  task automatic wait_caps(input int n, input int budget);
    int k;
    k = 0;
    while (cap_pc.size() < n && k < budget) begin
      step();
      k++;
    end
    chk1("capture_timeout", cap_pc.size() >= n, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_req"},    bus.MEM_REQ, 1'b0);
    chk16({tag, "_addr"},  bus.MEM_ADDR, 16'h0000);
    chk16({tag, "_instr"}, bus.INSTR, 16'h0000);
    chk16({tag, "_pc"},    bus.INSTR_PC, 16'h0000);
    chk1({tag, "_valid"},  bus.INSTR_VALID, 1'b0);
  endtask

  initial begin
    int spacing;
    spacing = (IFETCH_DEPTH == 1) ? 14 : 7;

    // Reset state
    step();
    step();
    chk_reset_outputs("rst");

    // First fetch, ACK one cycle after REQ
    nRESET = 1'b1;
    step();
    chk1("first_req", bus.MEM_REQ, 1'b1);
    chk16("first_addr", bus.MEM_ADDR, 16'h0000);
    step();
    man_ack = 1'b1;
    man_rdata = 16'h0813;
    step();
    man_ack = 1'b0;
    chk16("first_instr", bus.INSTR, 16'h0813);
    chk16("first_instr_pc", bus.INSTR_PC, 16'h0000);
    chk1("first_valid", bus.INSTR_VALID, 1'b1);
    chk16("next_addr", bus.MEM_ADDR, 16'h0001);
    chk1("req_after_fill", bus.MEM_REQ, IFETCH_DEPTH > 1);

    // Zero-wait streaming of eight instructions
    nRESET = 1'b0;
    auto_mem = 1'b1;
    ready = 1'b1;
    step();
    step();
    clear_caps();
    nRESET = 1'b1;
    wait_caps(8, 60);
    for (int i = 0; i < 8; i++) begin
      chk16($sformatf("stream_pc%0d", i), cap_pc[i], 16'(i));
      chk16($sformatf("stream_w%0d", i), cap_w[i], word_of(16'(i)));
    end
    chk16("stream_rate", 16'(cap_cyc[7] - cap_cyc[0]), 16'(spacing));

    // Back-pressure
    ready = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk16($sformatf("stall_pc%0d", i), bus.INSTR_PC, 16'h0008);
      chk16($sformatf("stall_w%0d", i), bus.INSTR, word_of(16'h0008));
      step();
    end
    chk1("stall_req_low", bus.MEM_REQ, 1'b0);
    chk1("stall_valid", bus.INSTR_VALID, 1'b1);
    clear_caps();
    ready = 1'b1;
    wait_caps(4, 40);
    for (int i = 0; i < 4; i++) begin
      chk16($sformatf("resume_pc%0d", i), cap_pc[i], 16'(8 + i));
    end

    // Branch while a request is outstanding (via a first flush to 0x0005)
    auto_mem = 1'b0;
    ready = 1'b0;
    nRESET = 1'b0;
    step();
    nRESET = 1'b1;
    step();
    branch = 1'b1;
    target = 16'h0005;
    step();
    branch = 1'b0;
    chk1("flush0_req", bus.MEM_REQ, 1'b1);
    chk16("flush0_stale_addr", bus.MEM_ADDR, 16'h0000);
    man_ack = 1'b1;
    man_rdata = 16'hDEAD;
    step();
    man_ack = 1'b0;
    chk1("flush0_valid", bus.INSTR_VALID, 1'b0);
    chk16("req5_addr", bus.MEM_ADDR, 16'h0005);
    branch = 1'b1;
    target = 16'h0040;
    step();
    branch = 1'b0;
    chk16("flush1_stale_addr", bus.MEM_ADDR, 16'h0005);
    chk1("flush1_req", bus.MEM_REQ, 1'b1);
    step();
    step();
    man_ack = 1'b1;
    man_rdata = word_of(16'h0005);
    step();
    man_ack = 1'b0;
    chk1("flush1_valid", bus.INSTR_VALID, 1'b0);
    chk1("tgt40_req", bus.MEM_REQ, 1'b1);
    chk16("tgt40_addr", bus.MEM_ADDR, 16'h0040);
    clear_caps();
    auto_mem = 1'b1;
    ready = 1'b1;
    wait_caps(1, 20);
    chk16("tgt40_first_pc", cap_pc[0], 16'h0040);
    chk16("tgt40_first_w", cap_w[0], word_of(16'h0040));

    // Branch coinciding with ACK
    auto_mem = 1'b0;
    ready = 1'b0;
    nRESET = 1'b0;
    step();
    nRESET = 1'b1;
    step();
    man_ack = 1'b1;
    man_rdata = 16'hBEEF;
    branch = 1'b1;
    target = 16'h0100;
    step();
    branch = 1'b0;
    chk1("coack_valid", bus.INSTR_VALID, 1'b0);
    chk1("coack_req", bus.MEM_REQ, 1'b1);
    chk16("coack_addr", bus.MEM_ADDR, 16'h0100);
    man_rdata = word_of(16'h0100);
    step();
    man_ack = 1'b0;
    chk1("tgt100_valid", bus.INSTR_VALID, 1'b1);
    chk16("tgt100_pc", bus.INSTR_PC, 16'h0100);
    chk16("tgt100_w", bus.INSTR, word_of(16'h0100));

    // Branch to the top of the address space
    auto_mem = 1'b1;
    branch = 1'b1;
    target = 16'hFFFF;
    step();
    branch = 1'b0;
    clear_caps();
    ready = 1'b1;
    wait_caps(2, 20);
    chk16("wrap_pc0", cap_pc[0], 16'hFFFF);
    chk16("wrap_pc1", cap_pc[1], 16'h0000);
    chk16("wrap_w1", cap_w[1], word_of(16'h0000));

    // Reset in the middle of a pending request; late ACK ignored
    auto_mem = 1'b0;
    step();
    step();
    step();
    chk1("pend_req", bus.MEM_REQ, 1'b1);
    ready = 1'b0;
    nRESET = 1'b0;
    man_ack = 1'b1;
    man_rdata = 16'h1234;
    step();
    chk_reset_outputs("midrst");
    nRESET = 1'b1;
    step();
    chk1("refetch_req", bus.MEM_REQ, 1'b1);
    chk16("refetch_addr", bus.MEM_ADDR, 16'h0000);
    chk1("late_ack_valid", bus.INSTR_VALID, 1'b0);
    man_rdata = word_of(16'h0000);
    step();
    man_ack = 1'b0;
    chk1("refetch_valid", bus.INSTR_VALID, 1'b1);
    chk16("refetch_pc", bus.INSTR_PC, 16'h0000);
    chk16("refetch_w", bus.INSTR, word_of(16'h0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the 16-bit instruction word consumed by the ALU decoder.
- Owns the program counter and issues req/ack reads to instruction memory.
- Buffers the returned words and presents them with a valid/ready handshake to decode/execute.
- Handles taken branches by flushing buffered and in-flight words.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- RESET_PC, 16'h0000, first fetch address after reset (ADDR_W bits).

Ports:
- CLK  input  1  clock, rising edge.
- nRESET  input  1  synchronous, active-low reset.
- MEM_REQ  output  1  read request; held until acknowledged.
- MEM_ADDR  output  ADDR_W  read address; stable while MEM_REQ=1.
- MEM_ACK  input  1  read complete; MEM_RDATA valid this cycle.
- MEM_RDATA  input  16  instruction word from memory.
- INSTR  output  16  instruction word to decoder (head of buffer).
- INSTR_PC  output  ADDR_W  address of INSTR.
- INSTR_VALID  output  1  INSTR/INSTR_PC valid.
- INSTR_READY  input  1  consumer accepts head when INSTR_VALID=1.
- BRANCH  input  1  single-cycle taken-branch pulse.
- BRANCH_TARGET  input  ADDR_W  new fetch address, sampled with BRANCH.

Behaviour:
- Reset (nRESET=0 at an edge):
  - MEM_REQ=0, MEM_ADDR=RESET_PC, INSTR=0, INSTR_PC=0, INSTR_VALID=0.
  - Buffer empty; state=FETCH_IDLE; fetch PC=RESET_PC.
  - A reset mid-transaction abandons the request; a late MEM_ACK is ignored.
- Buffer:
  - DEPTH=1 by default, 2 with the optional feature.
  - Entries hold {word, pc}; in-order; INSTR_VALID = occupancy>0.
- Issue rule, evaluated at each edge (MEM_REQ is registered):
  - Raise MEM_REQ next cycle when no request is outstanding and (next occupancy + 0) < DEPTH.
  - MEM_ADDR = fetch PC.
  - Only one request is ever outstanding.
- First fetch: MEM_REQ=1 in the first cycle after nRESET is sampled high.
- Memory handshake:
  - MEM_ACK may arrive in the same cycle MEM_REQ is first high.
  - At the ACK edge: push {MEM_RDATA, MEM_ADDR}, fetch PC += 1 mod 2^ADDR_W (16'hFFFF wraps to 16'h0000), drop MEM_REQ unless the issue rule re-raises it.
  - Data is visible on INSTR one cycle after ACK.
- Consume: a pop occurs at an edge where INSTR_VALID & INSTR_READY.
  - Simultaneous push and pop is legal.
  - Occupancy never exceeds DEPTH.
- FSM states:
  - FETCH_IDLE: no request. Go to FETCH_WAIT when the issue rule holds.
  - FETCH_WAIT: MEM_REQ=1, waiting for ACK. On ACK go to FETCH_WAIT (re-issue) or FETCH_IDLE.
  - FLUSH: MEM_REQ held at the stale address until ACK; data discarded; then FETCH_WAIT at the target.
- Branch (BRANCH=1 at an edge):
  - Buffer cleared, so INSTR_VALID=0 next cycle; a simultaneous pop is irrelevant.
  - Fetch PC = BRANCH_TARGET.
  - In FETCH_WAIT without ACK → FLUSH.
  - In FETCH_WAIT with ACK in the same cycle → word discarded, next state FETCH_WAIT at the target.
  - In FETCH_IDLE → FETCH_WAIT at the target.
  - BRANCH in FLUSH → target updated; state stays FLUSH.
- Throughput with zero-wait memory and INSTR_READY=1:
  - DEPTH=1: one instruction per 2 cycles.
  - DEPTH=2: one instruction per cycle.
- Back-pressure: with INSTR_READY=0, INSTR/INSTR_PC stay stable and fetching stops once the buffer is full.

Optional Feature:
- IFETCH_PREFETCH_EN defined: DEPTH=2 prefetch buffer, with full-rate streaming as above.
- Undefined: DEPTH=1 single instruction register; all other behaviour identical.

Decomposition:
- Shared package ifetch_pkg holds:
  - the FSM state enum {FETCH_IDLE, FETCH_WAIT, FLUSH};
  - the IFETCH_DEPTH constant selected by the macro;
  - the INSTR_W=16 constant.
- One natural sub-module: ifetch_buf, a small synchronous FIFO of {word, pc} with push/pop/clear, occupancy and full/empty flags.

Test Plan:
- Reset release, MEM_ACK one cycle after MEM_REQ, MEM_RDATA=16'h0813 → MEM_ADDR=16'h0000 first; INSTR=16'h0813, INSTR_PC=0, INSTR_VALID=1 the cycle after ACK; next MEM_ADDR=16'h0001.
- Zero-wait memory, INSTR_READY=1, 8 instructions → INSTR_PC sequence 0..7 in order, none lost or duplicated; one per 2 cycles without the macro, one per cycle with it.
- INSTR_READY=0 for 10 cycles → INSTR stable; MEM_REQ low once full; resuming yields the next sequential PC with no gaps.
- BRANCH to 16'h0040 while a request to 16'h0005 is outstanding, ACK 3 cycles later → data for 0x0005 discarded, INSTR_VALID=0; next MEM_ADDR=16'h0040, first valid INSTR_PC=16'h0040.
- BRANCH coinciding with MEM_ACK, target 16'h0100 → acked word never appears on INSTR; next request to 16'h0100.
- BRANCH to 16'hFFFF, two fetches → INSTR_PC 16'hFFFF then 16'h0000.
- nRESET low mid-FETCH_WAIT → all outputs at reset values next cycle; refetch from RESET_PC.
